// File: rtl/gray_conv_pkg.sv
// Shared types and defaults for the shared binary-to-Gray converter arbiter.
// The reference bin2gray here is meant for testbench models; the RTL uses bin2gray_core.
package gray_conv_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 4;
  localparam int MAX_WIDTH = 16;

  // Words narrower than MAX_WIDTH must be zero-extended by the caller.
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/bin2gray_core.sv
// Purely combinational binary-to-Gray converter of parameterised width.
module bin2gray_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray[WIDTH-1] = bin[WIDTH-1];

  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
    assign gray[gi] = bin[gi+1] ^ bin[gi];
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one bin2gray_core between NREQ requesters, with a
// single-entry output buffer. Optional macro GRAY_CONV_ARB_PARITY_EN adds rsp_par.
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter  int NREQ  = DEF_NREQ,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_bin,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_gray,
  output logic [IDW-1:0]        rsp_id,
  input  logic                  rsp_ready
`ifdef GRAY_CONV_ARB_PARITY_EN
  ,
  output logic                  rsp_par
`endif
);

  state_t           state_reg, state_next;
  logic [IDW-1:0]   ptr_reg, ptr_next;
  logic [IDW-1:0]   winner;
  logic             found;
  logic             accept;
  logic [WIDTH-1:0] winner_bin, winner_gray;
  logic [WIDTH-1:0] gray_reg;
  logic [IDW-1:0]   id_reg;

  // Scan requesters starting at the pointer; the extra bit absorbs the wrap.
  always_comb begin
    logic [IDW:0] idx;
    idx    = '0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_reg} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) begin
        idx = idx - (IDW+1)'(NREQ);
      end
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

  assign winner_bin = req_bin[int'(winner) * WIDTH +: WIDTH];

  bin2gray_core #(.WIDTH(WIDTH)) u_conv (
    .bin  (winner_bin),
    .gray (winner_gray)
  );

  // Reset gates the grant so nothing is acknowledged while rst_n is low.
  assign accept = rst_n && found && ((state_reg == EMPTY) || rsp_ready);

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = accept && (winner == IDW'(gi));
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (accept) begin
      ptr_next = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (rsp_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      ptr_reg   <= '0;
      gray_reg  <= '0;
      id_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      if (accept) begin
        gray_reg <= winner_gray;
        id_reg   <= winner;
      end
    end
  end

`ifdef GRAY_CONV_ARB_PARITY_EN
  logic par_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_reg <= 1'b0;
    end else if (accept) begin
      par_reg <= ^winner_gray;
    end
  end

  assign rsp_par = par_reg;
`endif

  assign rsp_valid = (state_reg == FULL);
  assign rsp_gray  = gray_reg;
  assign rsp_id    = id_reg;

endmodule
